// File: rtl/alu_multicycle.sv
// Handshaked multi-cycle execute ALU: single-cycle logic/arith/shift ops,
// iterative shift-add MUL, registered result with zero and signed-overflow flags.
module alu_multicycle #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             zero_o,
    output logic             ovf_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_XOR  = 3'b001,
        OP_SLL  = 3'b010,
        OP_ADD  = 3'b011,
        OP_SUB  = 3'b100,
        OP_MUL  = 3'b101,
        OP_ADDI = 3'b110,
        OP_SRAI = 3'b111
    } op_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_data;
    logic             r_zero;
    logic             r_ovf;
    logic             r_valid;
    logic             r_ready;
    logic [SHW:0]     r_cnt;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;

    op_t              w_op;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_add_ovf;
    logic             w_sub_ovf;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;
    logic [WIDTH-1:0] w_acc_nxt;

    assign w_op      = op_t'(ALUCtrl_i);
    assign w_shamt   = data2_i[SHW-1:0];
    assign w_sum     = data1_i + data2_i;
    assign w_diff    = data1_i - data2_i;
    assign w_add_ovf = (data1_i[WIDTH-1] == data2_i[WIDTH-1]) && (w_sum[WIDTH-1]  != data1_i[WIDTH-1]);
    assign w_sub_ovf = (data1_i[WIDTH-1] != data2_i[WIDTH-1]) && (w_diff[WIDTH-1] != data1_i[WIDTH-1]);

    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        unique case (w_op)
            OP_AND:  w_res = data1_i & data2_i;
            OP_XOR:  w_res = data1_i ^ data2_i;
            OP_SLL:  w_res = data1_i << w_shamt;
            OP_ADD,
            OP_ADDI: begin
                w_res = w_sum;
                w_ovf = w_add_ovf;
            end
            OP_SUB: begin
                w_res = w_diff;
                w_ovf = w_sub_ovf;
            end
            OP_SRAI: w_res = $signed(data1_i) >>> w_shamt;
            OP_MUL:  w_res = '0;
            default: w_res = '0;
        endcase
    end

    assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state  <= S_IDLE;
            r_data   <= '0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
            r_valid  <= 1'b0;
            r_ready  <= 1'b1;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (valid_i) begin
                        r_ready <= 1'b0;
                        if (w_op == OP_MUL) begin
                            r_mcand  <= data1_i;
                            r_mplier <= data2_i;
                            r_acc    <= '0;
                            r_cnt    <= (SHW+1)'(WIDTH);
                            r_state  <= S_MUL;
                        end else begin
                            r_data  <= w_res;
                            r_zero  <= (w_res == '0);
                            r_ovf   <= w_ovf;
                            r_valid <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_MUL: begin
                    r_acc    <= w_acc_nxt;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt - 1'b1;
                    // Final step: publish the accumulator including this step's add.
                    if (r_cnt == (SHW+1)'(1)) begin
                        r_data  <= w_acc_nxt;
                        r_zero  <= (w_acc_nxt == '0);
                        r_ovf   <= 1'b0;
                        r_valid <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (ready_i) begin
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ready_o = r_ready;
    assign valid_o = r_valid;
    assign data_o  = r_data;
    assign zero_o  = r_zero;
    assign ovf_o   = r_ovf;

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle (WIDTH=32): expected results are queued
// at issue and compared when the result handshake completes.
module tb_alu_multicycle;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [2:0]  ALUCtrl_i;
    logic [31:0] data1_i;
    logic [31:0] data2_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] data_o;
    logic        zero_o;
    logic        ovf_o;

    int n_total = 0;
    int n_bad   = 0;
    logic [33:0] q[$];

    alu_multicycle #(.WIDTH(32)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .ALUCtrl_i (ALUCtrl_i),
        .data1_i   (data1_i),
        .data2_i   (data2_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .data_o    (data_o),
        .zero_o    (zero_o),
        .ovf_o     (ovf_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model using 64-bit signed arithmetic; returns {ovf, zero, data}.
    function automatic logic [33:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint s  = 0;
        logic [31:0] r;
        logic [4:0]  sh = b[4:0];
        logic o = 1'b0;
        case (op)
            3'd0: r = a & b;
            3'd1: r = a ^ b;
            3'd2: r = a << sh;
            3'd3, 3'd6: begin
                s = sa + sb;
                r = s[31:0];
                o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd4: begin
                s = sa - sb;
                r = s[31:0];
                o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd5: begin
                s = sa * sb;
                r = s[31:0];
            end
            default: begin
                s = sa / (64'sd1 << sh);
                if (sa < 0 && (sa % (64'sd1 << sh)) != 0) s = s - 1;
                r = s[31:0];
            end
        endcase
        return {o, (r == 32'd0), r};
    endfunction

    always @(negedge clk_i) begin
        if (rst_i === 1'b1 && valid_o === 1'b1 && ready_i === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                logic [33:0] e;
                e = q.pop_front();
                chk("data", data_o, e[31:0]);
                chk("zero", zero_o, e[32]);
                chk("ovf",  ovf_o,  e[33]);
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit wait_res);
        int t = 0;
        int lat = 0;
        int nlow = 0;
        int exp_lat = (op == 3'd5) ? 32 : 0;
        @(negedge clk_i);
        while (ready_o !== 1'b1 && t < 200) begin
            @(negedge clk_i);
            t++;
        end
        if (ready_o !== 1'b1) begin
            chk("ready_timeout", 0, 1);
            return;
        end
        valid_i   = 1'b1;
        ALUCtrl_i = op;
        data1_i   = a;
        data2_i   = b;
        q.push_back(model(op, a, b));
        @(posedge clk_i);
        #1;
        valid_i   = 1'b0;
        data1_i   = $urandom;
        data2_i   = $urandom;
        ALUCtrl_i = 3'($urandom_range(0, 7));
        if (!wait_res) return;
        @(negedge clk_i);
        while (valid_o !== 1'b1 && lat < 200) begin
            if (ready_o === 1'b0) nlow++;
            data1_i = $urandom;
            data2_i = $urandom;
            @(posedge clk_i);
            lat++;
            @(negedge clk_i);
        end
        chk("latency", lat, exp_lat);
        if (op == 3'd5) chk("mul_ready_low", nlow, 32);
        chk("ready_while_valid", ready_o, 0);
        if (ready_i) begin
            @(posedge clk_i);
            #1;
            chk("ready_back", ready_o, 1);
            chk("valid_drop", valid_o, 0);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        ALUCtrl_i = '0; data1_i = '0; data2_i = '0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_valid", valid_o, 0);
        chk("rst_data",  data_o,  0);
        chk("rst_zero",  zero_o,  0);
        chk("rst_ovf",   ovf_o,   0);
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        @(posedge clk_i);
        #1 chk("rst_ready", ready_o, 1);

        issue(3'd3, 32'd5, 32'd7, 1);
        issue(3'd4, 32'h8000_0000, 32'd1, 1);
        issue(3'd1, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1);
        issue(3'd3, 32'h7FFF_FFFF, 32'd1, 1);
        issue(3'd6, 32'hFFFF_FFFF, 32'd1, 1);
        issue(3'd0, 32'hF0F0_1234, 32'h0FF0_FF00, 1);
        issue(3'd5, 32'hFFFF_FFFD, 32'd7, 1);
        issue(3'd5, 32'h0001_0000, 32'h0001_0000, 1);
        issue(3'd5, 32'h1234_5678, 32'h9ABC_DEF1, 1);
        issue(3'd7, 32'h8000_0000, 32'd35, 1);
        issue(3'd2, 32'd1, 32'd31, 1);
        issue(3'd2, 32'h0000_00FF, 32'd36, 1);

        // Backpressure: hold the ADD result, try to sneak in another op.
        ready_i = 1'b0;
        issue(3'd3, 32'd1, 32'd1, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i);
            #1;
            valid_i = 1'b1; ALUCtrl_i = 3'd3; data1_i = 32'd100; data2_i = 32'd100;
            @(negedge clk_i);
            chk("bp_valid", valid_o, 1);
            chk("bp_data",  data_o,  2);
            chk("bp_ready", ready_o, 0);
        end
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("bp_retire_valid", valid_o, 0);
        chk("bp_retire_ready", ready_o, 1);

        // Reset in the middle of a MUL discards it entirely.
        issue(3'd5, 32'd9, 32'd9, 0);
        repeat (9) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        chk("midrst_valid", valid_o, 0);
        chk("midrst_data",  data_o,  0);
        chk("midrst_ready", ready_o, 1);
        q.delete();
        rst_i = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk_i);
            if (valid_o !== 1'b0) seen = 1'b1;
        end
        chk("no_stale", seen, 0);
        issue(3'd5, 32'd6, 32'd7, 1);

        repeat (2) @(posedge clk_i);
        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
